// File: rtl/seg_scan_driver.sv
// seg_scan_driver: converts the calculator result to BCD with a sequential
// double-dabble, commits it atomically to display registers, and scans four
// active-low 7-segment digits (digit 0 = operand a in hex, 1..3 = H/T/U).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for load; display shows last committed value
// CONV    | double-dabble: add-3 / shift, eight shifts of {bcd,bin}
// COMMIT  | copy BCD nibbles and pending sign/a into display registers
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 65536,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       sign_in,
    input  logic [3:0] a,
    output logic       busy,
    output logic [1:0] digit_sel,
    output logic [3:0] segout,
    output logic [6:0] wordout,
    output logic       signout
);

    localparam int unsigned    PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_BLANK  = 7'b1111111;

    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    bin_q, bin_d;
    logic [11:0]   bcd_q, bcd_d, bcd_adj;
    logic [2:0]    cnt_q, cnt_d;
    logic          pend_sign_q, pend_sign_d;
    logic [3:0]    pend_a_q, pend_a_d;
    logic [3:0]    a_disp_q, a_disp_d;
    logic [3:0]    bcd_h_q, bcd_h_d, bcd_t_q, bcd_t_d, bcd_u_q, bcd_u_d;
    logic          sign_disp_q, sign_disp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // All state registers, cleared asynchronously so a reset aborts a conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            pend_sign_q <= 1'b0;
            pend_a_q    <= '0;
            a_disp_q    <= '0;
            bcd_h_q     <= '0;
            bcd_t_q     <= '0;
            bcd_u_q     <= '0;
            sign_disp_q <= 1'b0;
            presc_q     <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            pend_sign_q <= pend_sign_d;
            pend_a_q    <= pend_a_d;
            a_disp_q    <= a_disp_d;
            bcd_h_q     <= bcd_h_d;
            bcd_t_q     <= bcd_t_d;
            bcd_u_q     <= bcd_u_d;
            sign_disp_q <= sign_disp_d;
            presc_q     <= presc_d;
            sel_q       <= sel_d;
        end
    end

    // Conversion FSM; display registers are written only in COMMIT so the scan never tears.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        pend_sign_d = pend_sign_q;
        pend_a_d    = pend_a_q;
        a_disp_d    = a_disp_q;
        bcd_h_d     = bcd_h_q;
        bcd_t_d     = bcd_t_q;
        bcd_u_d     = bcd_u_q;
        sign_disp_d = sign_disp_q;
        bcd_adj     = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d       = value;
                    bcd_d       = '0;
                    pend_sign_d = sign_in;
                    pend_a_d    = a;
                    cnt_d       = '0;
                    state_d     = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                bcd_h_d     = bcd_q[11:8];
                bcd_t_d     = bcd_q[7:4];
                bcd_u_d     = bcd_q[3:0];
                a_disp_d    = pend_a_q;
                sign_disp_d = pend_sign_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running scan prescaler; digit advances on the prescaler wrap.
    always_comb begin
        presc_d = presc_q + 1'b1;
        sel_d   = sel_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            sel_d   = sel_q + 2'd1;
        end
    end

    // Digit enable, segment decode and leading-zero blanking.
    always_comb begin
        segout  = ~(4'b0001 << sel_q);
        wordout = seg7(a_disp_q);
        unique case (sel_q)
            2'd0: wordout = seg7(a_disp_q);
            2'd1: wordout = (BLANK_LZ && bcd_h_q == 4'd0) ? SEG_BLANK : seg7(bcd_h_q);
            2'd2: wordout = (BLANK_LZ && bcd_h_q == 4'd0 && bcd_t_q == 4'd0)
                            ? SEG_BLANK : seg7(bcd_t_q);
            default: wordout = seg7(bcd_u_q);
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign digit_sel = sel_q;
    assign signout   = sign_disp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (leading-zero blanking on/off)
// share stimulus; expected digits come from a decimal model via a scoreboard.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] value;
    logic       sign_in;
    logic [3:0] a;

    logic       busy, busy_n, sgn, sgn_n;
    logic [1:0] sel, sel_n;
    logic [3:0] seg, seg_n;
    logic [6:0] word, word_n;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][6:0] w1;
        logic [3:0][6:0] w0;
        logic            sign;
    } exp_t;

    exp_t            sb[$];
    logic [3:0][6:0] cur_w1, cur_w0;
    logic            cur_sign;

    int         m_presc;
    logic [1:0] m_sel;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .sign_in(sign_in), .a(a),
        .busy(busy), .digit_sel(sel), .segout(seg), .wordout(word), .signout(sgn)
    );

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .sign_in(sign_in), .a(a),
        .busy(busy_n), .digit_sel(sel_n), .segout(seg_n), .wordout(word_n), .signout(sgn_n)
    );

    always #5 clk = ~clk;

    // Reference scan position, SCAN_DIV = 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc <= 0;
            m_sel   <= 2'd0;
        end else if (m_presc == 3) begin
            m_presc <= 0;
            m_sel   <= m_sel + 2'd1;
        end else begin
            m_presc <= m_presc + 1;
        end
    end

    function automatic logic [6:0] seg7(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001;  14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0][6:0] model(input int v, input int av, input bit blank);
        logic [3:0][6:0] r;
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        r[0] = seg7(av);
        r[1] = (blank && h == 0) ? 7'b1111111 : seg7(h);
        r[2] = (blank && h == 0 && t == 0) ? 7'b1111111 : seg7(t);
        r[3] = seg7(u);
        return r;
    endfunction

    task automatic test_reset();
        logic [3:0] exp_seg;
        rst_n = 1'b0; load = 1'b0; value = '0; sign_in = 1'b0; a = '0;
        #3;
        checks++;
        if (busy !== 1'b0 || seg !== 4'b1110 || word !== 7'b1000000 || sgn !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b seg=%b word=%b sign=%b sel=%0d exp 0 1110 1000000 0 0",
                     busy, seg, word, sgn, sel);
        end
        cur_w1 = model(0, 0, 1'b1);
        cur_w0 = model(0, 0, 1'b0);
        cur_sign = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_seg = ~(4'b0001 << (k / 4));
            checks++;
            if (seg !== exp_seg || word !== cur_w1[k/4] || word_n !== cur_w0[k/4] || seg_n !== exp_seg) begin
                errors++;
                $display("FAIL reset_scan k=%0d: seg=%b word=%b word_nb=%b exp seg=%b word=%b word_nb=%b",
                         k, seg, word, word_n, exp_seg, cur_w1[k/4], cur_w0[k/4]);
            end
            @(negedge clk);
        end
    endtask

    // Caller must be at a negedge. ign_at > 0 drives a second load (value 99)
    // sampled at edge N+ign_at, which must be ignored.
    task automatic test_load_convert(input int v, input int av, input bit s, input int ign_at, input bit do_scan);
        exp_t       e;
        int         cycles;
        logic [3:0] exp_seg;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_load: busy=%b exp 0", busy);
        end
        e.w1 = model(v, av, 1'b1);
        e.w0 = model(v, av, 1'b0);
        e.sign = s;
        sb.push_back(e);
        load = 1'b1; value = 8'(v); a = 4'(av); sign_in = s;
        @(negedge clk);
        load = 1'b0; value = 8'($urandom); a = 4'($urandom); sign_in = 1'($urandom);
        cycles = 0;
        while (busy === 1'b1 && cycles < 30) begin
            cycles++;
            checks++;
            if (word !== cur_w1[m_sel] || word_n !== cur_w0[m_sel] || sgn !== cur_sign) begin
                errors++;
                $display("FAIL old_display cyc=%0d: word=%b word_nb=%b sign=%b exp %b %b %b",
                         cycles, word, word_n, sgn, cur_w1[m_sel], cur_w0[m_sel], cur_sign);
            end
            if (cycles == ign_at) begin
                load = 1'b1; value = 8'd99;
            end
            @(negedge clk);
            load = 1'b0;
        end
        checks++;
        if (cycles !== 9) begin
            errors++;
            $display("FAIL busy_cycles value=%0d: got=%0d exp=9", v, cycles);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cur_w1 = e.w1;
            cur_w0 = e.w0;
            cur_sign = e.sign;
        end
        if (do_scan) begin
            for (int k = 0; k < 16; k++) begin
                exp_seg = ~(4'b0001 << m_sel);
                checks++;
                if (sel !== m_sel || seg !== exp_seg || seg_n !== exp_seg || busy !== 1'b0 ||
                    word !== cur_w1[m_sel] || word_n !== cur_w0[m_sel] ||
                    sgn !== cur_sign || sgn_n !== cur_sign) begin
                    errors++;
                    $display("FAIL scan value=%0d k=%0d: sel=%0d seg=%b busy=%b word=%b word_nb=%b sign=%b exp sel=%0d seg=%b busy=0 word=%b word_nb=%b sign=%b",
                             v, k, sel, seg, busy, word, word_n, sgn, m_sel, exp_seg,
                             cur_w1[m_sel], cur_w0[m_sel], cur_sign);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_load_convert(17, 3, 1'b0, 0, 1'b0);
        test_load_convert(200, 15, 1'b1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        load = 1'b1; value = 8'd88; a = 4'h5; sign_in = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b exp 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || seg !== 4'b1110 || word !== 7'b1000000 || sgn !== 1'b0 ||
            word_n !== 7'b1000000 || sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b seg=%b word=%b word_nb=%b sign=%b sel=%0d exp 0 1110 1000000 1000000 0 0",
                     busy, seg, word, word_n, sgn, sel);
        end
        cur_w1 = model(0, 0, 1'b1);
        cur_w0 = model(0, 0, 1'b0);
        cur_sign = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (busy !== 1'b0 || sel !== m_sel || word !== cur_w1[m_sel] ||
                word_n !== cur_w0[m_sel] || sgn !== 1'b0) begin
                errors++;
                $display("FAIL post_reset k=%0d: busy=%b sel=%0d word=%b word_nb=%b sign=%b exp 0 %0d %b %b 0",
                         k, busy, sel, word, word_n, sgn, m_sel, cur_w1[m_sel], cur_w0[m_sel]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_load_convert(255, 12, 1'b0, 0, 1'b1);
        test_load_convert(7, 0, 1'b1, 0, 1'b1);
        test_load_convert(100, 9, 1'b0, 0, 1'b1);
        test_load_convert(42, 0, 1'b0, 3, 1'b1);
        test_load_convert(63, 10, 1'b1, 9, 1'b1);
        test_back_to_back();
        test_load_convert(0, 1, 1'b1, 0, 1'b1);
        test_load_convert(109, 14, 1'b0, 0, 1'b1);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "watchdog");
    end

endmodule
